tag_range_engine: RTL and testbench

- Command-driven initiator for the per-byte DIFT tag memory.
- Walks a byte range word by word. For each word it either:
  - writes one tag value (SET/CLEAR) with byte enables, or
  - reads tags and reports how many bytes in the range are tainted, plus the first tainted byte address (SCAN).
- Sits between the debug/CSR side and the tag RAM port. Used for bulk taint initialisation and taint audits.

---
 rtl/tag_range_engine.sv | 211 +++++++++++++++++++++
 tb/tb_tag_range_engine.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_range_engine.sv
// rtl/tag_range_engine.sv - command-driven SET/CLEAR/SCAN walker for the per-byte DIFT tag RAM
// Optional abort_i input is built in when TAG_RANGE_ENGINE_ABORT_EN is defined.
module tag_range_engine #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rstn_i,
    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [1:0]               cmd_op_i,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]     cmd_len_i,
`ifdef TAG_RANGE_ENGINE_ABORT_EN
    input  logic                     abort_i,
`endif
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic                     scan_hit_o,
    output logic [ADDR_WIDTH-1:0]    scan_first_o,
    output logic [LEN_WIDTH:0]       scan_count_o,
    output logic                     tag_en_o,
    output logic                     tag_we_o,
    output logic [ADDR_WIDTH-1:0]    tag_addr_o,
    output logic                     tag_wdata_o,
    output logic [DATA_WIDTH/8-1:0]  tag_be_o,
    input  logic [DATA_WIDTH/8-1:0]  tag_rdata_i
);

    localparam int B  = DATA_WIDTH / 8;
    localparam int LB = $clog2(B);
    localparam int SW = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(B - 1);
    localparam logic [B-1:0]          ALL_LANES = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              op_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic [ADDR_WIDTH-1:0]   last_word_q;
    logic [LB-1:0]           start_lo_q;
    logic [LB-1:0]           end_lo_q;
    logic                    first_q;
    logic                    range_err_q;
    logic                    err_q;
    logic                    rd_valid_q;
    logic [B-1:0]            rd_mask_q;
    logic [ADDR_WIDTH-1:0]   rd_addr_q;
    logic                    hit_q;
    logic [ADDR_WIDTH-1:0]   first_addr_q;
    logic [LEN_WIDTH:0]      count_q;

    logic                    accept;
    logic                    run;
    logic                    is_scan;
    logic                    is_last;
    logic                    abort_hit;
    logic [SW-1:0]           end_full;
    logic                    over;
    logic [ADDR_WIDTH-1:0]   end_clamped;
    logic [B-1:0]            lane_mask;
    logic [B-1:0]            rd_masked;

    function automatic logic [LB:0] lane_popcount(input logic [B-1:0] v);
        logic [LB:0] n;
        n = '0;
        for (int i = 0; i < B; i++) begin
            n = n + (LB + 1)'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [LB-1:0] lowest_lane(input logic [B-1:0] v);
        logic [LB-1:0] idx;
        idx = '0;
        for (int i = B - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = LB'(i);
            end
        end
        return idx;
    endfunction

    assign accept  = (state_q == S_IDLE) && cmd_valid_i;
    assign run     = (state_q == S_RUN);
    assign is_scan = op_q[1];
    assign is_last = (cur_addr_q == last_word_q);

`ifdef TAG_RANGE_ENGINE_ABORT_EN
    assign abort_hit = run && abort_i;
`else
    assign abort_hit = 1'b0;
`endif

    // End address is formed one bit wider than the address space so overflow is visible, then clamped.
    assign end_full    = SW'(cmd_addr_i) + SW'(cmd_len_i) - SW'(1);
    assign over        = |end_full[SW-1:ADDR_WIDTH];
    assign end_clamped = over ? '1 : end_full[ADDR_WIDTH-1:0];

    always_comb begin
        lane_mask = ALL_LANES;
        if (first_q) begin
            lane_mask = lane_mask & (ALL_LANES << start_lo_q);
        end
        if (is_last) begin
            lane_mask = lane_mask & (ALL_LANES >> (LB'(B - 1) - end_lo_q));
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (cmd_len_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (is_last || abort_hit) begin
                    state_d = is_scan ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_masked = tag_rdata_i & rd_mask_q;

    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            cur_addr_q   <= '0;
            last_word_q  <= '0;
            start_lo_q   <= '0;
            end_lo_q     <= '0;
            first_q      <= 1'b0;
            range_err_q  <= 1'b0;
            err_q        <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_mask_q    <= '0;
            rd_addr_q    <= '0;
            hit_q        <= 1'b0;
            first_addr_q <= '0;
            count_q      <= '0;
        end else begin
            state_q <= state_d;
            // Read pipeline stage: mask and word address travel with the read so they meet tag_rdata_i.
            rd_valid_q <= run && is_scan;
            rd_mask_q  <= lane_mask;
            rd_addr_q  <= cur_addr_q;
            if (accept) begin
                op_q         <= cmd_op_i;
                cur_addr_q   <= cmd_addr_i & WORD_MASK;
                last_word_q  <= end_clamped & WORD_MASK;
                start_lo_q   <= cmd_addr_i[LB-1:0];
                end_lo_q     <= end_clamped[LB-1:0];
                first_q      <= 1'b1;
                range_err_q  <= over;
                err_q        <= 1'b0;
                hit_q        <= 1'b0;
                first_addr_q <= '0;
                count_q      <= '0;
            end else begin
                if (run) begin
                    cur_addr_q <= cur_addr_q + ADDR_WIDTH'(B);
                    first_q    <= 1'b0;
                end
                if (abort_hit) begin
                    range_err_q <= 1'b1;
                end
                if (rd_valid_q) begin
                    count_q <= count_q + (LEN_WIDTH + 1)'(lane_popcount(rd_masked));
                    if (!hit_q && (|rd_masked)) begin
                        hit_q        <= 1'b1;
                        first_addr_q <= rd_addr_q + ADDR_WIDTH'(lowest_lane(rd_masked));
                    end
                end
                // Zero-length commands go IDLE->DONE and never raise an error.
                if ((state_d == S_DONE) && (run || (state_q == S_DRAIN))) begin
                    err_q <= range_err_q || abort_hit;
                end
            end
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = err_q;
    assign scan_hit_o   = hit_q;
    assign scan_first_o = first_addr_q;
    assign scan_count_o = count_q;

    assign tag_en_o    = run;
    assign tag_we_o    = run && !is_scan;
    assign tag_addr_o  = run ? cur_addr_q : '0;
    assign tag_wdata_o = run && !is_scan && op_q[0];
    assign tag_be_o    = run ? lane_mask : '0;

endmodule

// File: tb/tb_tag_range_engine.sv
// tb/tb_tag_range_engine.sv - scoreboard bench for tag_range_engine with a byte-level reference model
module tb_tag_range_engine;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [3:0]  be;
        logic        wd;
    } acc_t;

    typedef struct {
        logic        err;
        logic [16:0] cnt;
        logic        hit;
        logic [15:0] first;
        int          cyc;
    } res_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        busy;
    logic        done;
    logic        err;
    logic        scan_hit;
    logic [15:0] scan_first;
    logic [16:0] scan_count;
    logic        tag_en;
    logic        tag_we;
    logic [15:0] tag_addr;
    logic        tag_wdata;
    logic [3:0]  tag_be;
    logic [3:0]  tag_rdata = '0;
`ifdef TAG_RANGE_ENGINE_ABORT_EN
    logic        abort;
`endif

    bit   ram     [0:65535];
    bit   ref_mem [0:65535];
    acc_t acc_q[$];
    res_t res_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   spurious = 0;
    bit   ignore = 1'b0;

    tag_range_engine #(
        .ADDR_WIDTH(16),
        .DATA_WIDTH(32),
        .LEN_WIDTH (16)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_addr_i  (cmd_addr),
        .cmd_len_i   (cmd_len),
`ifdef TAG_RANGE_ENGINE_ABORT_EN
        .abort_i     (abort),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .scan_hit_o  (scan_hit),
        .scan_first_o(scan_first),
        .scan_count_o(scan_count),
        .tag_en_o    (tag_en),
        .tag_we_o    (tag_we),
        .tag_addr_o  (tag_addr),
        .tag_wdata_o (tag_wdata),
        .tag_be_o    (tag_be),
        .tag_rdata_i (tag_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tag RAM: byte-enabled writes, read data one cycle after an enabled read.
    always @(posedge clk) begin
        if (tag_en) begin
            for (int i = 0; i < 4; i++) begin
                if (tag_we) begin
                    if (tag_be[i]) ram[int'(tag_addr) + i] <= tag_wdata;
                end else begin
                    tag_rdata[i] <= ram[int'(tag_addr) + i];
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the byte range, group bytes into words, update or count tags byte by byte.
    task automatic push_model(input logic [1:0] op, input int s, input int l, input int max_words, input int a);
        int   e;
        int   w0;
        int   nw;
        bit   rerr;
        res_t r;
        acc_t x;
        r = '{err: 1'b0, cnt: '0, hit: 1'b0, first: '0, cyc: a};
        if (l == 0) begin
            res_q.push_back(r);
            return;
        end
        e    = s + l - 1;
        rerr = 1'b0;
        if (e > 65535) begin
            e    = 65535;
            rerr = 1'b1;
        end
        w0 = s & ~3;
        nw = ((e & ~3) - w0) / 4 + 1;
        if (max_words < nw) begin
            nw   = max_words;
            rerr = 1'b1;
        end
        for (int k = 0; k < nw; k++) begin
            int w;
            w      = w0 + 4 * k;
            x.we   = !op[1];
            x.addr = 16'(w);
            x.wd   = op[1] ? 1'b0 : op[0];
            x.be   = '0;
            for (int ln = 0; ln < 4; ln++) begin
                if (w + ln >= s && w + ln <= e) begin
                    x.be[ln] = 1'b1;
                    if (!op[1]) begin
                        ref_mem[w + ln] = op[0];
                    end else if (ref_mem[w + ln]) begin
                        if (!r.hit) begin
                            r.hit   = 1'b1;
                            r.first = 16'(w + ln);
                        end
                        r.cnt = r.cnt + 17'd1;
                    end
                end
            end
            acc_q.push_back(x);
        end
        r.err = rerr;
        r.cyc = a + nw + (op[1] ? 1 : 0);
        res_q.push_back(r);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 500 && !cmd_ready; i++) begin
            @(posedge clk);
            #1;
        end
        if (!cmd_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_ready: got cmd_ready=%b expected 1 within 500 cycles", cmd_ready);
            $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
            $fatal(1, "engine stuck busy");
        end
    endtask

    task automatic issue(input logic [1:0] op, input int s, input int l, input int abort_after);
        int a;
        wait_ready();
        cmd_op    = op;
        cmd_addr  = 16'(s);
        cmd_len   = 16'(l);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        a = cyc;
        push_model(op, s, l, (abort_after > 0) ? abort_after : 32'h4000_0000, a);
        if (abort_after == 0 && $urandom_range(0, 3) == 0) begin
            cmd_op   = 2'($urandom);
            cmd_addr = 16'($urandom);
            cmd_len  = 16'($urandom_range(1, 8));
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
`ifdef TAG_RANGE_ENGINE_ABORT_EN
        if (abort_after > 0) begin
            repeat (abort_after - 1) begin
                @(posedge clk);
                #1;
            end
            abort = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
        end
`endif
    endtask

    // Monitor: pops and compares every RAM access and every completion.
    initial begin
        acc_t x;
        res_t r;
        forever begin
            @(negedge clk);
            if (rstn && !ignore) begin
                if (tag_en) begin
                    n_vec++;
                    if (acc_q.size() == 0) begin
                        n_err++;
                        $display("FAIL access_extra: got access addr=%h we=%b be=%b expected none", tag_addr, tag_we, tag_be);
                    end else begin
                        x = acc_q.pop_front();
                        if ({tag_we, tag_addr, tag_be, tag_wdata} !== {x.we, x.addr, x.be, x.wd}) begin
                            n_err++;
                            $display("FAIL access: got we=%b addr=%h be=%b wd=%b expected we=%b addr=%h be=%b wd=%b",
                                     tag_we, tag_addr, tag_be, tag_wdata, x.we, x.addr, x.be, x.wd);
                        end
                    end
                end
                if (done) begin
                    n_vec++;
                    if (res_q.size() == 0) begin
                        n_err++;
                        $display("FAIL done_extra: got done at cycle %0d expected none", cyc);
                    end else begin
                        r = res_q.pop_front();
                        if ({err, scan_count, scan_hit, scan_first} !== {r.err, r.cnt, r.hit, r.first} || cyc != r.cyc) begin
                            n_err++;
                            $display("FAIL done: got err=%b cnt=%0d hit=%b first=%h cyc=%0d expected err=%b cnt=%0d hit=%b first=%h cyc=%0d",
                                     err, scan_count, scan_hit, scan_first, cyc, r.err, r.cnt, r.hit, r.first, r.cyc);
                        end
                    end
                end
            end else if (ignore && done) begin
                spurious++;
            end
        end
    end

    initial begin
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_len   = '0;
`ifdef TAG_RANGE_ENGINE_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready_busy_done", {61'd0, cmd_ready, busy, done}, 64'b100);
        check("reset_err_hit", {62'd0, err, scan_hit}, 64'd0);
        check("reset_scan_first", 64'(scan_first), 64'd0);
        check("reset_scan_count", 64'(scan_count), 64'd0);
        check("reset_tag_port", {57'd0, tag_en, tag_we, tag_wdata, tag_be}, 64'd0);

        issue(2'd1, 'h0005, 6, 0);
        issue(2'd0, 'h0000, 16, 0);
        issue(2'd1, 'h0002, 1, 0);
        issue(2'd1, 'h0004, 1, 0);
        issue(2'd1, 'h0007, 1, 0);
        issue(2'd1, 'h0008, 1, 0);
        issue(2'd2, 'h0002, 6, 0);
        issue(2'd2, 'h0002, 8, 0);
        issue(2'd2, 'h0010, 0, 0);
        issue(2'd1, 'hFFFE, 8, 0);
        issue(2'd3, 'hFFF0, 32, 0);

        // Reset two cycles into a 16-word SET: no done, engine returns to IDLE.
        wait_ready();
        ignore    = 1'b1;
        cmd_op    = 2'd1;
        cmd_addr  = 16'h0400;
        cmd_len   = 16'd64;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_ready_busy_done", {61'd0, cmd_ready, busy, done}, 64'b100);
        check("midreset_tag_en", 64'(tag_en), 64'd0);
        rstn = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        ignore = 1'b0;
        check("midreset_no_done", 64'(spurious), 64'd0);
        for (int i = 0; i < 65536; i++) ref_mem[i] = ram[i];
        issue(2'd2, 'h0400, 64, 0);

`ifdef TAG_RANGE_ENGINE_ABORT_EN
        issue(2'd0, 'h0200, 64, 0);
        issue(2'd1, 'h0201, 3, 0);
        issue(2'd1, 'h020E, 1, 0);
        issue(2'd1, 'h0215, 2, 0);
        issue(2'd2, 'h0200, 40, 4);
        issue(2'd1, 'h0300, 40, 3);
`endif

        for (int n = 0; n < 200; n++) begin
            int s;
            int l;
            s = ($urandom_range(0, 5) == 0) ? 65535 - int'($urandom_range(0, 40)) : int'($urandom_range(0, 1023));
            l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 48));
            issue(2'($urandom_range(0, 3)), s, l, 0);
        end

        for (int i = 0; i < 2000 && (acc_q.size() != 0 || res_q.size() != 0 || !cmd_ready); i++) begin
            @(posedge clk);
            #1;
        end
        check("acc_q_drained", 64'(acc_q.size()), 64'd0);
        check("res_q_drained", 64'(res_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
